// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and the nibble-to-ASCII helper for the LCD hex driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// LCD_LABEL_EN selects whether each line carries a 4-character text prefix.
package lcd_pkg;

  // HD44780 command bytes used by the init sequence and line addressing
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display, needs the long wait
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment address, no shift
  localparam logic [7:0] ADDR_L1      = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] ADDR_L2      = 8'hC0;  // DDRAM address 0x40

  // Wide enough for the longest delay (power-up, 750000 clocks)
  localparam int CNT_W = 20;

`ifdef LCD_LABEL_EN
  localparam int PREFIX_CHARS = 4;
`else
  localparam int PREFIX_CHARS = 0;
`endif
  localparam int HEX_CHARS  = 8;
  localparam int LINE_CHARS = PREFIX_CHARS + HEX_CHARS;

  typedef enum logic [3:0] {
    PWRUP, INIT0, INIT1, INIT2, INIT3,
    L1_ADDR, L1_CHAR, L2_ADDR, L2_CHAR, GAP
  } lcd_state_t;

  typedef enum logic [2:0] {
    W_IDLE, W_SETUP, W_EN, W_WAIT, W_DONE
  } wr_state_t;

  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    // '0'..'9' then uppercase 'A'..'F'
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Writes one byte to an HD44780 bus: latch RS/DATA, pulse EN, then wait for the controller.
// Latency: accept edge + 1 setup + EN_CYCLES + post-EN wait, then a 1-cycle done pulse.
// Backpressure: byte_rdy is high only while idle; byte_vld is taken on byte_vld & byte_rdy.
// Ports: clk, rst (sync, active-high); byte_vld/byte_rdy/byte_rs/byte_dat request side;
//        done pulse; lcd_en/lcd_rs/lcd_dat to the panel.
module lcd_byte_writer #(
  parameter int EN_CYCLES       = 25,
  parameter int CMD_WAIT_CYCLES = 2000,
  parameter int CLR_WAIT_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_vld,
  output logic       byte_rdy,
  input  logic       byte_rs,
  input  logic [7:0] byte_dat,
  output logic       done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_dat
);
  import lcd_pkg::*;

  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT_CYCLES - 1);

  wr_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_clr;
  logic [CNT_W-1:0] wait_last;

  assign wait_last = is_clr ? CLR_LAST : CMD_LAST;

  // State register, phase counter and the held bus value
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= W_IDLE;
      cnt     <= '0;
      is_clr  <= 1'b0;
      lcd_rs  <= 1'b0;
      lcd_dat <= '0;
    end else begin
      state <= state_nxt;
      // counter restarts on every phase change so each phase counts from zero
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
      if (state == W_IDLE && byte_vld) begin
        lcd_rs  <= byte_rs;
        lcd_dat <= byte_dat;
        is_clr  <= !byte_rs && (byte_dat == CMD_CLEAR);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      W_IDLE:  if (byte_vld) state_nxt = W_SETUP;
      W_SETUP: state_nxt = W_EN;
      W_EN:    if (cnt == EN_LAST) state_nxt = W_WAIT;
      W_WAIT:  if (cnt == wait_last) state_nxt = W_DONE;
      W_DONE:  state_nxt = W_IDLE;
      default: state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    byte_rdy = (state == W_IDLE);
    lcd_en   = (state == W_EN);
    done     = (state == W_DONE);
  end

endmodule

// File: rtl/lcd_hex_driver.sv
// Shows the selector's PC nibbles on line 1 and the selected word on line 2 of a 16x2 LCD, as hex.
// Latency: PWRUP_CYCLES + init, then one frame per (bytes x byte time) + GAP_CYCLES.
// Backpressure: none; the panel is write-only and pacing comes from fixed wait counts.
// Ports: clk, rst (sync, active-high); ix1..ix8 PC nibbles, iy select code, iz1..iz8 data
//        nibbles (1 = LS); LCD_DATA/LCD_RS/LCD_RW/LCD_EN/LCD_ON panel pins; frame_done pulse.
// Build option: define LCD_LABEL_EN for "PC  "/"Sy  " prefixes (12 chars per line), else 8.
module lcd_hex_driver #(
  parameter int EN_CYCLES       = 25,
  parameter int CMD_WAIT_CYCLES = 2000,
  parameter int CLR_WAIT_CYCLES = 82000,
  parameter int PWRUP_CYCLES    = 750000,
  parameter int GAP_CYCLES      = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ix1, ix2, ix3, ix4, ix5, ix6, ix7, ix8,
  input  logic [3:0] iy,
  input  logic [3:0] iz1, iz2, iz3, iz4, iz5, iz6, iz7, iz8,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       frame_done
);
  import lcd_pkg::*;

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       CHAR_LAST  = 4'(LINE_CHARS - 1);

  lcd_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       char_idx;
  logic             char_last;
  logic             lcd_on_q;

  // Frame snapshot, taken once per frame so a frame never mixes old and new inputs
  logic [31:0] ix_s, iz_s;
`ifdef LCD_LABEL_EN
  logic [3:0]  iy_s;
`endif

  logic       byte_vld, byte_rdy, byte_rs, w_done;
  logic [7:0] byte_dat;
  logic [2:0] hex_pos;
  logic [3:0] l1_nib, l2_nib;
  logic [7:0] line1_chr, line2_chr;

  assign char_last = (char_idx == CHAR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PWRUP;
      cnt      <= '0;
      char_idx <= '0;
      lcd_on_q <= 1'b0;
      ix_s     <= '0;
      iz_s     <= '0;
`ifdef LCD_LABEL_EN
      iy_s     <= '0;
`endif
    end else begin
      state    <= state_nxt;
      lcd_on_q <= 1'b1;
      if (state_nxt != state)
        cnt <= '0;
      else if (state == PWRUP || state == GAP)
        cnt <= cnt + 1'b1;
      // character index restarts at each line start and advances per completed byte
      if (state_nxt != state)
        char_idx <= '0;
      else if (w_done)
        char_idx <= char_idx + 1'b1;
      if (state_nxt == L1_ADDR && state != L1_ADDR) begin
        ix_s <= {ix8, ix7, ix6, ix5, ix4, ix3, ix2, ix1};
        iz_s <= {iz8, iz7, iz6, iz5, iz4, iz3, iz2, iz1};
`ifdef LCD_LABEL_EN
        iy_s <= iy;
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PWRUP:   if (cnt == PWRUP_LAST) state_nxt = INIT0;
      INIT0:   if (w_done) state_nxt = INIT1;
      INIT1:   if (w_done) state_nxt = INIT2;
      INIT2:   if (w_done) state_nxt = INIT3;
      INIT3:   if (w_done) state_nxt = L1_ADDR;
      L1_ADDR: if (w_done) state_nxt = L1_CHAR;
      L1_CHAR: if (w_done && char_last) state_nxt = L2_ADDR;
      L2_ADDR: if (w_done) state_nxt = L2_CHAR;
      L2_CHAR: if (w_done && char_last) state_nxt = GAP;
      GAP:     if (cnt == GAP_LAST) state_nxt = L1_ADDR;
      default: state_nxt = PWRUP;
    endcase
  end

  // Character generation: hex digits run MS nibble first after the optional prefix
  always_comb begin
    hex_pos = 3'(char_idx - 4'(PREFIX_CHARS));
    l1_nib  = ix_s[{~hex_pos, 2'b00} +: 4];
    l2_nib  = iz_s[{~hex_pos, 2'b00} +: 4];
    line1_chr = hex2ascii(l1_nib);
    line2_chr = hex2ascii(l2_nib);
`ifdef LCD_LABEL_EN
    case (char_idx)
      4'd0: begin
        line1_chr = 8'h50;  // 'P'
        line2_chr = 8'h53;  // 'S'
      end
      4'd1: begin
        line1_chr = 8'h43;  // 'C'
        line2_chr = hex2ascii(iy_s);
      end
      4'd2, 4'd3: begin
        line1_chr = 8'h20;
        line2_chr = 8'h20;
      end
      default: ;
    endcase
`endif
  end

  // Byte request: offered whenever the writer is idle in a sending state
  always_comb begin
    byte_vld   = 1'b0;
    byte_rs    = 1'b0;
    byte_dat   = 8'h00;
    frame_done = 1'b0;
    case (state)
      INIT0:   begin byte_vld = byte_rdy; byte_dat = CMD_FUNC_SET; end
      INIT1:   begin byte_vld = byte_rdy; byte_dat = CMD_DISP_ON;  end
      INIT2:   begin byte_vld = byte_rdy; byte_dat = CMD_CLEAR;    end
      INIT3:   begin byte_vld = byte_rdy; byte_dat = CMD_ENTRY;    end
      L1_ADDR: begin byte_vld = byte_rdy; byte_dat = ADDR_L1;      end
      L1_CHAR: begin byte_vld = byte_rdy; byte_rs = 1'b1; byte_dat = line1_chr; end
      L2_ADDR: begin byte_vld = byte_rdy; byte_dat = ADDR_L2;      end
      L2_CHAR: begin
        byte_vld   = byte_rdy;
        byte_rs    = 1'b1;
        byte_dat   = line2_chr;
        frame_done = w_done && char_last;
      end
      default: ;
    endcase
  end

  lcd_byte_writer #(
    .EN_CYCLES      (EN_CYCLES),
    .CMD_WAIT_CYCLES(CMD_WAIT_CYCLES),
    .CLR_WAIT_CYCLES(CLR_WAIT_CYCLES)
  ) u_writer (
    .clk     (clk),
    .rst     (rst),
    .byte_vld(byte_vld),
    .byte_rdy(byte_rdy),
    .byte_rs (byte_rs),
    .byte_dat(byte_dat),
    .done    (w_done),
    .lcd_en  (LCD_EN),
    .lcd_rs  (LCD_RS),
    .lcd_dat (LCD_DATA)
  );

  assign LCD_RW = 1'b0;
  assign LCD_ON = lcd_on_q;

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Scoreboarded bench for lcd_hex_driver with short timing parameters.
// Expected bytes are built as text strings from the input words and queued; a monitor
// pops one entry per LCD_EN rising edge and also checks EN width, hold, gaps and frame size.
module tb_lcd_hex_driver;

  localparam int EN_C  = 2;
  localparam int CMD_C = 4;
  localparam int CLR_C = 10;
  localparam int PWR_C = 20;
  localparam int GAP_C = 8;
`ifdef LCD_LABEL_EN
  localparam bit LABEL       = 1'b1;
  localparam int FRAME_BYTES = 26;
`else
  localparam bit LABEL       = 1'b0;
  localparam int FRAME_BYTES = 18;
`endif
  localparam int LINE_LEN = FRAME_BYTES / 2 - 1;
  localparam int L2_FIRST = LINE_LEN + 3;  // frame byte number of the first line-2 char
  localparam int NF       = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ix_w, iz_w;
  logic [3:0]  iy;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS, LCD_RW, LCD_EN, LCD_ON, frame_done;

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q[$];

  // monitor state, shared with the stimulus for progress tracking
  int  cyc = 0;
  int  frames = 0;
  int  frame_bytes = 0;
  int  pulses = 0;
  int  en_w = 0;
  int  last_fall = 0;
  int  rel_cyc = 0;
  bit  en_p = 0, fd_p = 0, rst_p = 1, unstable = 0, have_fall = 0;
  bit  was_clr = 0, fd_valid = 0, await_first = 0;
  logic [8:0] held;
  logic [8:0] got;

  always #5 clk = ~clk;

  lcd_hex_driver #(
    .EN_CYCLES(EN_C), .CMD_WAIT_CYCLES(CMD_C), .CLR_WAIT_CYCLES(CLR_C),
    .PWRUP_CYCLES(PWR_C), .GAP_CYCLES(GAP_C)
  ) dut (
    .clk(clk), .rst(rst),
    .ix1(ix_w[3:0]),   .ix2(ix_w[7:4]),   .ix3(ix_w[11:8]),  .ix4(ix_w[15:12]),
    .ix5(ix_w[19:16]), .ix6(ix_w[23:20]), .ix7(ix_w[27:24]), .ix8(ix_w[31:28]),
    .iy(iy),
    .iz1(iz_w[3:0]),   .iz2(iz_w[7:4]),   .iz3(iz_w[11:8]),  .iz4(iz_w[15:12]),
    .iz5(iz_w[19:16]), .iz6(iz_w[23:20]), .iz7(iz_w[27:24]), .iz8(iz_w[31:28]),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_ON(LCD_ON), .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic string hex_text(input logic [31:0] w, input int digits);
    string hexd = "0123456789ABCDEF";
    string s = "";
    for (int k = digits - 1; k >= 0; k--) begin
      int n = int'((w >> (4 * k)) & 32'hF);
      s = {s, hexd.substr(n, n)};
    end
    return s;
  endfunction

  task automatic push_byte(input bit rs, input logic [7:0] d);
    exp_q.push_back({rs, d});
  endtask

  task automatic push_init();
    push_byte(0, 8'h38);
    push_byte(0, 8'h0C);
    push_byte(0, 8'h01);
    push_byte(0, 8'h06);
  endtask

  // The text the panel should show for the current input values
  task automatic push_frame();
    string l1, l2;
    if (LABEL) begin
      l1 = {"PC  ", hex_text(ix_w, 8)};
      l2 = {"S", hex_text({28'h0, iy}, 1), "  ", hex_text(iz_w, 8)};
    end else begin
      l1 = hex_text(ix_w, 8);
      l2 = hex_text(iz_w, 8);
    end
    push_byte(0, 8'h80);
    for (int i = 0; i < l1.len(); i++) push_byte(1, l1[i]);
    push_byte(0, 8'hC0);
    for (int i = 0; i < l2.len(); i++) push_byte(1, l2[i]);
  endtask

  task automatic wait_frame(output bit ok);
    int f0 = frames;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frames != f0) begin ok = 1; return; end
    end
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_bytes >= n) begin ok = 1; return; end
    end
  endtask

  // Monitor: one scoreboard pop per EN rising edge plus timing checks
  initial begin : monitor
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        en_p = 0; fd_p = 0; have_fall = 0; fd_valid = 0;
        pulses = 0; frame_bytes = 0; rst_p = 1;
        continue;
      end
      if (rst_p) begin
        rel_cyc = cyc; await_first = 1; rst_p = 0;
      end
      got = {LCD_RS, LCD_DATA};
      if (LCD_EN && !en_p) begin
        pulses++;
        frame_bytes++;
        if (got == 9'h080) frame_bytes = 1;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_byte: got 0x%0h with nothing expected (cycle %0d)", got, cyc);
        end else begin
          check("byte", got, exp_q.pop_front());
        end
        check("rw_low", LCD_RW, 0);
        if (await_first) check("pwrup_delay_ok", (cyc - rel_cyc) >= PWR_C, 1);
        await_first = 0;
        if (have_fall) check("en_gap_ok", (cyc - last_fall) >= (was_clr ? CLR_C : CMD_C), 1);
        held = got; en_w = 1; unstable = 0;
      end else if (LCD_EN && en_p) begin
        en_w++;
        if (got != held) unstable = 1;
      end else if (!LCD_EN && en_p) begin
        check("en_width", en_w, EN_C);
        check("en_hold_stable", unstable, 0);
        last_fall = cyc; have_fall = 1; was_clr = (held == 9'h001);
      end
      if (frame_done) begin
        check("frame_done_width", fd_p, 0);
        if (fd_valid) check("en_per_frame", pulses, FRAME_BYTES);
        fd_valid = 1; pulses = 0; frame_bytes = 0; frames++;
      end
      en_p = LCD_EN;
      fd_p = frame_done;
    end
  end

  initial begin : stimulus
    bit ok;
    rst = 1'b1;
    ix_w = $urandom; iz_w = $urandom; iy = 4'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, frame_done}, 0);
    @(negedge clk);
    rst = 1'b0;
    push_init();
    @(posedge clk); #1;
    check("lcd_on_after_reset", LCD_ON, 1);
    // inputs moving during power-up only matter once the first frame snapshots them
    repeat (4) @(negedge clk);
    ix_w = 32'h004000AC; iy = 4'h2; iz_w = 32'hDEADBEEF;
    push_frame();

    for (int f = 0; f < NF; f++) begin
      if (f == 0) begin
        // change in the middle of line 2: this frame must still show DEADBEEF
        wait_bytes(L2_FIRST + 2, ok);
        if (!ok) begin tests++; fails++; $display("FAIL timeout_mid_line2"); break; end
        iz_w = 32'h12345678;
      end else if (f == 3) begin
        wait_bytes(L2_FIRST + 2, ok);
        if (!ok) begin tests++; fails++; $display("FAIL timeout_reset_point"); break; end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("midframe_reset_outputs",
              {LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, frame_done}, 0);
        @(negedge clk);
        rst = 1'b0;
        push_init();
        push_frame();
        @(posedge clk); #1;
        check("lcd_on_after_midreset", LCD_ON, 1);
      end else if (f >= 4 && $urandom_range(1) == 1) begin
        // only after the address byte, so the snapshot is already taken
        wait_bytes($urandom_range(FRAME_BYTES - 1, 2), ok);
        if (!ok) begin tests++; fails++; $display("FAIL timeout_mid_change"); break; end
        ix_w = $urandom; iz_w = $urandom; iy = 4'($urandom);
      end

      wait_frame(ok);
      if (!ok) begin tests++; fails++; $display("FAIL timeout_frame_done"); break; end

      if (f == 1) begin
        ix_w = 32'h0; iy = 4'hF; iz_w = 32'hFFFFFFFF;
      end else if (f >= 2) begin
        ix_w = $urandom; iz_w = $urandom; iy = 4'($urandom);
      end
      push_frame();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
